// File: rtl/cim_core_ctrl.sv
// Sequencer for one 3x3 CIM Core: weight load, activation streaming and PSUM window handshake.
// Optional weight read-back is enabled with the CIM_CORE_CTRL_RDBK_EN macro.

// One activation register per Core row feeding column 0.
module cim_act_lane #(
  parameter int A_W = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [A_W-1:0] d,
  output logic [A_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end
endmodule

module cim_core_ctrl #(
  parameter int ROWS   = 64,
  parameter int ADDR_W = 6,
  parameter int W_W    = 288,
  parameter int A_W    = 256,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_load,
  input  logic               start_compute,
  input  logic [CNT_W-1:0]   num_cols,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [W_W-1:0]     w_data,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [3*A_W-1:0]   act_data,
  output logic               psum_valid,
  input  logic               psum_ready,
  output logic               core_stdw,
  output logic               core_stdr,
  output logic [ADDR_W-1:0]  core_std_a,
  output logic [W_W-1:0]     core_weight_in,
  output logic [A_W-1:0]     core_act_in1,
  output logic [A_W-1:0]     core_act_in2,
  output logic [A_W-1:0]     core_act_in3,
  output logic               core_slide_en,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef CIM_CORE_CTRL_RDBK_EN
  ,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic [W_W-1:0]     core_weight_out,
  output logic               rd_valid,
  output logic [W_W-1:0]     rd_data
`endif
);

  typedef enum logic [2:0] {
    IDLE, WLOAD, WLAST, COMP, CDRAIN
`ifdef CIM_CORE_CTRL_RDBK_EN
    , RDREQ, RDOUT
`endif
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   row_cnt, row_d;
  logic [CNT_W-1:0]    acc_cnt, acc_d;
  logic [CNT_W-1:0]    ncols_q, ncols_d;
  logic                stdw_q, stdw_d;
  logic [ADDR_W-1:0]   std_a_q, std_a_d;
  logic [W_W-1:0]      wdata_q, wdata_d;
  logic                pv_q, pv_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                w_hs, act_hs, ps_hs;
  logic [2:0][A_W-1:0] act_q;

  assign w_ready   = (state == WLOAD);
  // Back-pressure: a stalled window must keep the Core columns frozen.
  assign act_ready = (state == COMP) && !(pv_q && !psum_ready);
  assign w_hs      = w_valid && w_ready;
  assign act_hs    = act_valid && act_ready;
  assign ps_hs     = pv_q && psum_ready;

`ifdef CIM_CORE_CTRL_RDBK_EN
  logic           stdr_q, stdr_d;
  logic           rdv_q;
  logic [W_W-1:0] rdd_q;
`endif

  always_comb begin
    state_d = state;
    row_d   = row_cnt;
    acc_d   = acc_cnt;
    ncols_d = ncols_q;
    stdw_d  = 1'b0;
    std_a_d = std_a_q;
    wdata_d = wdata_q;
    pv_d    = pv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef CIM_CORE_CTRL_RDBK_EN
    stdr_d  = 1'b0;
`endif
    if (ps_hs) pv_d = 1'b0;
    // Third and later vectors complete a window; a new window wins over a consume.
    if (act_hs && (acc_cnt >= CNT_W'(2))) pv_d = 1'b1;
    case (state)
      IDLE: begin
        if (start_load) begin
          state_d = WLOAD;
          row_d   = '0;
        end else if (start_compute) begin
          if (num_cols < CNT_W'(3)) begin
            err_d = 1'b1;
          end else begin
            state_d = COMP;
            ncols_d = num_cols;
            acc_d   = '0;
          end
        end
`ifdef CIM_CORE_CTRL_RDBK_EN
        else if (rd_req) begin
          state_d = RDREQ;
          stdr_d  = 1'b1;
          std_a_d = rd_addr;
        end
`endif
      end
      WLOAD: begin
        if (w_hs) begin
          wdata_d = w_data;
          std_a_d = row_cnt;
          stdw_d  = 1'b1;
          row_d   = row_cnt + ADDR_W'(1);
          if (row_cnt == ADDR_W'(ROWS-1)) state_d = WLAST;
        end
      end
      WLAST: begin
        done_d  = 1'b1;
        row_d   = '0;
        state_d = IDLE;
      end
      COMP: begin
        if (act_hs) begin
          acc_d = acc_cnt + CNT_W'(1);
          if (acc_cnt == ncols_q - CNT_W'(1)) state_d = CDRAIN;
        end
      end
      CDRAIN: begin
        if (ps_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef CIM_CORE_CTRL_RDBK_EN
      RDREQ:   state_d = RDOUT;
      RDOUT:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      acc_cnt <= '0;
      ncols_q <= '0;
      stdw_q  <= 1'b0;
      std_a_q <= '0;
      wdata_q <= '0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      row_cnt <= row_d;
      acc_cnt <= acc_d;
      ncols_q <= ncols_d;
      stdw_q  <= stdw_d;
      std_a_q <= std_a_d;
      wdata_q <= wdata_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_lane
    cim_act_lane #(.A_W(A_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .ld  (act_hs),
      .d   (act_data[i*A_W +: A_W]),
      .q   (act_q[i])
    );
  end

`ifdef CIM_CORE_CTRL_RDBK_EN
  // Read data is captured during the STDR cycle and presented the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      stdr_q <= 1'b0;
      rdv_q  <= 1'b0;
      rdd_q  <= '0;
    end else begin
      stdr_q <= stdr_d;
      rdv_q  <= (state == RDREQ);
      if (state == RDREQ) rdd_q <= core_weight_out;
    end
  end
  assign core_stdr = stdr_q;
  assign rd_valid  = rdv_q;
  assign rd_data   = rdd_q;
`else
  assign core_stdr = 1'b0;
`endif

  assign core_stdw      = stdw_q;
  assign core_std_a     = std_a_q;
  assign core_weight_in = wdata_q;
  assign core_act_in1   = act_q[0];
  assign core_act_in2   = act_q[1];
  assign core_act_in3   = act_q[2];
  assign core_slide_en  = act_hs;
  assign psum_valid     = pv_q;
  assign busy           = (state != IDLE);
  assign done           = done_q;
  assign err            = err_q;

endmodule
